word_byte_serializer: RTL and testbench
=======================================

Name: word_byte_serializer

Overview:
- Splits 16-bit words into a byte stream: upper byte [15:8] first, then lower byte [7:0].
- This is the inverse of the byte-to-upper-half placement used for immediate loads.
- Sits between the 16-bit datapath and any 8-bit sink, such as a byte port or debug UART.
- Input side has a small word FIFO so the producer can run ahead of the byte consumer.
- Both sides use a valid/ready handshake.

Parameters:
- DEPTH, 2, number of 16-bit words buffered. Must be a power of 2, minimum 2.
- CNT_W, 2, width of Count. Must equal log2(DEPTH)+1.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- WordIn  input  16  word to serialize.
- WordValid  input  1  WordIn is valid this cycle.
- WordReady  output  1  block can accept a word this cycle.
- ByteOut  output  8  current output byte.
- ByteValid  output  1  ByteOut is valid.
- ByteReady  input  1  sink accepts ByteOut this cycle.
- ByteHigh  output  1  1 = ByteOut is the upper byte of its word; 0 = lower byte.
- Count  output  CNT_W  number of words held, including a partially sent word.
- Busy  output  1  Count != 0.

Behaviour:
- Reset (asynchronous, active-high) clears read/write pointers, count and the phase bit.
- Values during and immediately after reset:
  - WordReady = 1, ByteValid = 0, ByteOut = 8'h00, ByteHigh = 1, Count = 0, Busy = 0.
  - FIFO storage need not be cleared.
- Word push:
  - A word is pushed when WordValid && WordReady at a rising CLK edge.
  - WordReady = (Count != DEPTH).
  - No same-cycle bypass: when full, WordReady stays 0 even if a pop happens that cycle.
- Byte phase: a phase register selects the byte of the head word.
  - Phase 0: ByteOut = head[15:8], ByteHigh = 1.
  - Phase 1: ByteOut = head[7:0], ByteHigh = 0.
- ByteValid = (Count != 0).
- When empty, ByteOut = 8'h00.
- Output paths:
  - All outputs are decoded from registered state only.
  - There is no combinational path from WordValid/WordIn/ByteReady to any output.
- Byte transfer occurs when ByteValid && ByteReady.
  - In phase 0, the transfer sets phase to 1; the head word is retained.
  - In phase 1, the transfer pops the head, sets phase to 0 and decrements the count.
- Latency: a word accepted at edge N is presented as its upper byte from edge N (after the edge) when the FIFO was empty. Its first byte is therefore visible in the cycle following acceptance.
- Throughput: 1 byte per cycle while ByteReady is held high. Sustained input is 1 word per 2 cycles.
- Simultaneous push and pop-of-head in the same cycle: Count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- ByteReady low: ByteOut, ByteHigh and ByteValid hold stable until the transfer.
- WordIn while not ready: data is ignored and nothing is pushed.
- Reset mid-word (phase 1): remaining bytes are discarded. Output restarts at phase 0 with an empty FIFO.

Optional Feature:
- Macro: WBS_LOW_FIRST_SEL_EN.
- Defined:
  - Adds input port LowFirst (1 bit), sampled and stored alongside each word at push.
  - For words pushed with LowFirst = 1, phase 0 emits [7:0] with ByteHigh = 0, then phase 1 emits [15:8] with ByteHigh = 1.
  - FIFO width becomes 17 bits.
  - When empty, ByteHigh = 1.
- Undefined:
  - No LowFirst port.
  - Order is always upper byte then lower byte, exactly as above.

Test Plan:
- Reset:
  - Assert Reset mid-cycle with no clock.
  - Expect WordReady = 1, ByteValid = 0, ByteOut = 8'h00, Count = 0 immediately.
- Single word:
  - Push 16'hA55A with ByteReady = 1.
  - Expect bytes 8'hA5 (ByteHigh = 1), then 8'h5A (ByteHigh = 0) on consecutive cycles.
  - Expect Count to go 1 then 0.
- Fill and backpressure:
  - ByteReady = 0, push 16'h1234, 16'h5678.
  - Expect WordReady = 0 and Count = 2, and a third word (16'h9ABC) not accepted.
  - Then set ByteReady = 1: expect stream 12, 34, 56, 78, and WordReady back to 1 after byte 34.
- Stall mid-word:
  - Push 16'hBEEF; accept 8'hBE; drop ByteReady for 3 cycles.
  - Expect ByteOut = 8'hEF and ByteHigh = 0 held stable for all 3 cycles.
- Streaming/wrap:
  - Push 8 words 16'h0001 to 16'h0008 with ByteReady = 1 continuously.
  - Expect 16 bytes in order 00, 01, 00, 02, … 00, 08, with no loss or duplication across pointer wrap.
  - Expect simultaneous push/pop to keep Count steady.
- Reset mid-word:
  - After 8'hCA of 16'hCAFE is sent, assert Reset.
  - Expect ByteValid = 0 and Count = 0; 8'hFE is never emitted.
  - With WBS_LOW_FIRST_SEL_EN, push 16'hCAFE with LowFirst = 1: expect FE (ByteHigh = 0), then CA (ByteHigh = 1).

Source files
------------

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: buffers 16-bit words in a small FIFO and emits them as a
// byte stream, upper byte first. Valid/ready handshake on both sides.
// Optional feature macro: WBS_LOW_FIRST_SEL_EN adds a per-word low_first flag
// stored with the word. Words pushed with low_first = 1 emit the lower byte first.
// All outputs are decoded from registered state only.
module word_byte_serializer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      word_in,
  input  logic             word_valid,
`ifdef WBS_LOW_FIRST_SEL_EN
  input  logic             low_first,
`endif
  output logic             word_ready,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             byte_high,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef WBS_LOW_FIRST_SEL_EN
  localparam int DW = 17;
`else
  localparam int DW = 16;
`endif

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  logic [DW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  phase_t           phase_r;
  phase_t           phase_s;
  logic [DW-1:0]    din_s;
  logic [DW-1:0]    head_s;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             xfer_s;
  logic             pop_s;
  logic             sel_low_s;

`ifdef WBS_LOW_FIRST_SEL_EN
  assign din_s     = {low_first, word_in};
  assign sel_low_s = (phase_r == PH_SECOND) ^ head_s[16];
`else
  assign din_s     = word_in;
  assign sel_low_s = (phase_r == PH_SECOND);
`endif

  assign head_s  = mem_r[rd_ptr_r];
  assign empty_s = (count_r == {CNT_W{1'b0}});
  // Full is judged on the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign push_s  = word_valid && !full_s;
  assign xfer_s  = !empty_s && byte_ready;
  assign pop_s   = xfer_s && (phase_r == PH_SECOND);

  assign word_ready = !full_s;
  assign byte_valid = !empty_s;
  assign count      = count_r;
  assign busy       = !empty_s;

  // Select the presented byte of the head word from the phase and order flag.
  always_comb begin
    byte_out  = 8'h00;
    byte_high = 1'b1;
    if (empty_s) begin
      byte_out  = 8'h00;
      byte_high = 1'b1;
    end else if (sel_low_s) begin
      byte_out  = head_s[7:0];
      byte_high = 1'b0;
    end else begin
      byte_out  = head_s[15:8];
      byte_high = 1'b1;
    end
  end

  // Next phase and next word count from the two handshakes.
  always_comb begin
    phase_s = phase_r;
    count_s = count_r;
    case (phase_r)
      PH_FIRST: begin
        if (xfer_s) phase_s = PH_SECOND;
        else        phase_s = PH_FIRST;
      end
      PH_SECOND: begin
        if (xfer_s) phase_s = PH_FIRST;
        else        phase_s = PH_SECOND;
      end
      default: phase_s = PH_FIRST;
    endcase
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
  end

  // Pointer, count and phase registers; reset discards any partly sent word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      phase_r  <= PH_FIRST;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_s;
      phase_r <= phase_s;
    end
  end

  // Word storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din_s;
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Scoreboard bench for word_byte_serializer: directed scenarios followed by
// random traffic, checked against a byte-queue reference model.
module tb_word_byte_serializer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
`ifdef WBS_LOW_FIRST_SEL_EN
  localparam bit LF_EN = 1'b1;
`else
  localparam bit LF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      word_in = 16'h0000;
  logic             word_valid = 1'b0;
  logic             lf = 1'b0;
  logic             word_ready;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready = 1'b0;
  logic             byte_high;
  logic [CNT_W-1:0] count;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int bytes_seen = 0;

  // Expected bytes in emission order: {byte_high, byte}.
  logic [8:0] exp_q [$];

  word_byte_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
`ifdef WBS_LOW_FIRST_SEL_EN
    .low_first  (lf),
`endif
    .word_ready (word_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_high  (byte_high),
    .count      (count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model mid-cycle, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      int words;
      bit m_valid;
      bit m_ready;
      words   = (exp_q.size() + 1) / 2;
      m_valid = (exp_q.size() != 0);
      m_ready = (words != DEPTH);
      check("word_ready", {15'd0, word_ready}, {15'd0, m_ready});
      check("byte_valid", {15'd0, byte_valid}, {15'd0, m_valid});
      check("count", {{(16-CNT_W){1'b0}}, count}, 16'(words));
      check("busy", {15'd0, busy}, {15'd0, m_valid});
      if (m_valid) begin
        check("byte_out", {8'd0, byte_out}, {8'd0, exp_q[0][7:0]});
        check("byte_high", {15'd0, byte_high}, {15'd0, exp_q[0][8]});
        if (byte_ready) begin
          void'(exp_q.pop_front());
          bytes_seen++;
        end
      end else begin
        check("idle_byte_out", {8'd0, byte_out}, 16'h0000);
        check("idle_byte_high", {15'd0, byte_high}, 16'h0001);
      end
      if (word_valid && m_ready) begin
        if (lf && LF_EN) begin
          exp_q.push_back({1'b0, word_in[7:0]});
          exp_q.push_back({1'b1, word_in[15:8]});
        end else begin
          exp_q.push_back({1'b1, word_in[15:8]});
          exp_q.push_back({1'b0, word_in[7:0]});
        end
      end
    end
  end

  // One clock cycle with the given inputs held from just after an edge to the next edge.
  task automatic cyc(input logic wv, input logic [15:0] w, input logic br, input logic l);
    word_valid = wv;
    word_in    = w;
    byte_ready = br;
    lf         = l;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs checked before any clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check({tag, "_word_ready"}, {15'd0, word_ready}, 16'h0001);
    check({tag, "_byte_valid"}, {15'd0, byte_valid}, 16'h0000);
    check({tag, "_byte_out"}, {8'd0, byte_out}, 16'h0000);
    check({tag, "_byte_high"}, {15'd0, byte_high}, 16'h0001);
    check({tag, "_count"}, {{(16-CNT_W){1'b0}}, count}, 16'h0000);
    check({tag, "_busy"}, {15'd0, busy}, 16'h0000);
    word_valid = 1'b0;
    byte_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int total_bytes;
    // Power-on reset.
    @(posedge clk);
    #1;
    async_reset("reset");
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Single word.
    cyc(1'b1, 16'hA55A, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Fill and backpressure; the third word must be refused.
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    cyc(1'b1, 16'h5678, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 16'h9ABC, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Stall mid-word.
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Streaming across pointer wrap.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 16'(i), 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    repeat (3) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Reset mid-word: FE must never appear afterwards.
    cyc(1'b1, 16'hCAFE, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    async_reset("midword_reset");
    repeat (3) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Low-first order (plain order when the feature is absent).
    cyc(1'b1, 16'hCAFE, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)));
    end
    repeat (8) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    total_bytes = bytes_seen;
    checks++;
    if (total_bytes < 40) begin
      failures++;
      $display("FAIL byte_traffic actual=%0d required_at_least=40", total_bytes);
    end
    check("drained", 16'(exp_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
